// File: rtl/intra_pred_sched.sv
// intra_pred_sched
// ----------------
// Per-macroblock scheduler for the shared 16x16 intra predictor (DC/TM/V/H).
// On an accepted MB request it latches the MB coordinates and the set of
// prediction modes legal at that position. It then runs the predictor once
// per legal mode, in the order DC, TM, V, H. Each completed prediction is
// offered downstream, and a one-cycle end-of-MB report closes the MB.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mb_start, mb_ready      MB request; accepted when both are high (IDLE only)
//   mb_x, mb_y              MB column / row, sampled at accept
//   pred_start              one-cycle launch pulse to the predictor
//   pred_mode               mode being launched (0 DC, 1 TM, 2 V, 3 H)
//   pred_x, pred_y          latched MB coordinates
//   pred_done               predictor completion level; its rising edge counts
//   res_valid, res_mode     prediction result offered downstream
//   res_ready               downstream acceptance
//   mb_done                 one-cycle end-of-MB pulse
//   mb_err                  with mb_done: 1 = MB aborted by predictor timeout
//   mb_mode_cnt             with mb_done: results accepted for this MB (0..4)
//   busy                    high whenever the scheduler is not idle
//
// Result handshake: res_valid rises only in OUT. res_valid and res_mode stay
// stable until res_ready is high on a rising clock edge. That edge completes
// the transfer, and res_valid drops on the next cycle. res_ready has no effect
// while res_valid is low.
//
// Every output comes from a register or is decoded from the state register.
// No input has a combinational path to an output.

module intra_pred_sched #(
   parameter int         BLOCK_NUM   = 10,
   parameter logic [3:0] MODE_EN     = 4'b1111,
   parameter int         TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mb_start,
   output logic                 mb_ready,
   input  logic [BLOCK_NUM-1:0] mb_x,
   input  logic [BLOCK_NUM-1:0] mb_y,
   output logic                 pred_start,
   output logic [1:0]           pred_mode,
   output logic [BLOCK_NUM-1:0] pred_x,
   output logic [BLOCK_NUM-1:0] pred_y,
   input  logic                 pred_done,
   output logic                 res_valid,
   output logic [1:0]           res_mode,
   input  logic                 res_ready,
   output logic                 mb_done,
   output logic                 mb_err,
   output logic [2:0]           mb_mode_cnt,
   output logic                 busy
);

   localparam int            TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_OUT    = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic [BLOCK_NUM-1:0]  x_q, x_d;
   logic [BLOCK_NUM-1:0]  y_q, y_d;
   logic [3:0]            mask_q, mask_d;
   logic [1:0]            mode_q, mode_d;
   logic [1:0]            res_mode_q, res_mode_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  pred_done_d_q;

   logic [3:0]            acc_mask;
   logic                  done_edge;
   logic [2:0]            first_pick;
   logic [2:0]            next_pick;

   // Returns {found, mode}: the lowest set mask bit at index >= lo.
   function automatic logic [2:0] pick_mode(input logic [3:0] mask, input int lo);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (i >= lo && mask[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   // Legal modes at the requested position. Modes that need a left or an
   // upper neighbour are dropped on the picture edges.
   always_comb begin
      acc_mask[0] = MODE_EN[0];
      acc_mask[1] = MODE_EN[1] & (mb_x != '0) & (mb_y != '0);
      acc_mask[2] = MODE_EN[2] & (mb_y != '0);
      acc_mask[3] = MODE_EN[3] & (mb_x != '0);
   end

   // A level that was already high before this cycle is not a completion.
   assign done_edge  = pred_done & ~pred_done_d_q;
   assign first_pick = pick_mode(acc_mask, 0);
   assign next_pick  = pick_mode(mask_q, int'(mode_q) + 1);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      mask_d     = mask_q;
      mode_d     = mode_q;
      res_mode_d = res_mode_q;
      tcnt_d     = tcnt_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (mb_start) begin
               x_d    = mb_x;
               y_d    = mb_y;
               mask_d = acc_mask;
               cnt_d  = 3'd0;
               err_d  = 1'b0;
               if (first_pick[2]) begin
                  mode_d  = first_pick[1:0];
                  state_d = ST_LAUNCH;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_LAUNCH: begin
            tcnt_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion in the cycle the timeout expires still counts.
            if (done_edge) begin
               res_mode_d = mode_q;
               state_d    = ST_OUT;
            end else if (tcnt_q == T_LAST) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_OUT: begin
            if (res_ready) begin
               cnt_d = cnt_q + 3'd1;
               if (next_pick[2]) begin
                  mode_d  = next_pick[1:0];
                  state_d = ST_LAUNCH;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         mask_q        <= '0;
         mode_q        <= '0;
         res_mode_q    <= '0;
         tcnt_q        <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         pred_done_d_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         mask_q        <= mask_d;
         mode_q        <= mode_d;
         res_mode_q    <= res_mode_d;
         tcnt_q        <= tcnt_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         pred_done_d_q <= pred_done;
      end
   end

   assign mb_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign pred_start  = (state_q == ST_LAUNCH);
   assign res_valid   = (state_q == ST_OUT);
   assign mb_done     = (state_q == ST_FINISH);
   assign pred_mode   = mode_q;
   assign pred_x      = x_q;
   assign pred_y      = y_q;
   assign res_mode    = res_mode_q;
   assign mb_err      = err_q;
   assign mb_mode_cnt = cnt_q;

endmodule

// File: tb/tb_intra_pred_sched.sv
// Testbench for intra_pred_sched.
// The main instance uses the default parameters. A second instance with
// MODE_EN=4'b1110 covers the empty-mask path. Expected mode sequences come
// from the mode-legality rules, evaluated per MB position.

module tb_intra_pred_sched;

   localparam int BN = 10;
   localparam int TO = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          mb_start = 1'b0, mb_start_e = 1'b0;
   logic [BN-1:0] mb_x = '0, mb_y = '0;
   logic          pred_done = 1'b0, res_ready = 1'b0;

   logic          mb_ready, pred_start, res_valid, mb_done, mb_err, busy;
   logic [1:0]    pred_mode, res_mode;
   logic [BN-1:0] pred_x, pred_y;
   logic [2:0]    mb_mode_cnt;

   logic          mb_ready_e, pred_start_e, res_valid_e, mb_done_e, mb_err_e, busy_e;
   logic [1:0]    pred_mode_e, res_mode_e;
   logic [BN-1:0] pred_x_e, pred_y_e;
   logic [2:0]    mb_mode_cnt_e;

   intra_pred_sched #(.BLOCK_NUM(BN), .MODE_EN(4'b1111), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .mb_start(mb_start), .mb_ready(mb_ready),
      .mb_x(mb_x), .mb_y(mb_y), .pred_start(pred_start), .pred_mode(pred_mode),
      .pred_x(pred_x), .pred_y(pred_y), .pred_done(pred_done),
      .res_valid(res_valid), .res_mode(res_mode), .res_ready(res_ready),
      .mb_done(mb_done), .mb_err(mb_err), .mb_mode_cnt(mb_mode_cnt), .busy(busy)
   );

   intra_pred_sched #(.BLOCK_NUM(BN), .MODE_EN(4'b1110), .TIMEOUT_CYC(TO)) dut_e (
      .clk(clk), .rst_n(rst_n), .mb_start(mb_start_e), .mb_ready(mb_ready_e),
      .mb_x(mb_x), .mb_y(mb_y), .pred_start(pred_start_e), .pred_mode(pred_mode_e),
      .pred_x(pred_x_e), .pred_y(pred_y_e), .pred_done(pred_done),
      .res_valid(res_valid_e), .res_mode(res_mode_e), .res_ready(res_ready),
      .mb_done(mb_done_e), .mb_err(mb_err_e), .mb_mode_cnt(mb_mode_cnt_e), .busy(busy_e)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Observations recorded by run_mb
   logic [10:0] obs_pack;
   int obs_done, obs_err, obs_cnt, obs_bad_xy, obs_unstable, obs_rv_cycles;
   int obs_lat_min, obs_lat_max;

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference: {count[2:0], slot0..slot3 modes} of the legal modes, in issue order.
   function automatic logic [10:0] model_pack(input int x, input int y, input logic [3:0] en);
      logic [10:0] p;
      bit          legal[4];
      int          k;
      legal[0] = en[0];
      legal[1] = en[1] && x != 0 && y != 0;
      legal[2] = en[2] && y != 0;
      legal[3] = en[3] && x != 0;
      p = '0;
      k = 0;
      for (int m = 0; m < 4; m++) begin
         if (legal[m]) begin
            p[7-2*k -: 2] = 2'(m);
            k++;
         end
      end
      p[10:8] = 3'(k);
      return p;
   endfunction

   // ---------------- driver: plays predictor and downstream for one MB ----------------
   // lat: cycles from pred_start to the pred_done pulse; bp: res_ready low cycles per result.
   task automatic run_mb(input logic [BN-1:0] x, input logic [BN-1:0] y, input int lat, input int bp);
      int cyc, ref_cyc, done_at, bp_left, k, l;
      bit in_out;
      logic [1:0] held, last_mode;
      obs_pack = '0; obs_done = 0; obs_err = -1; obs_cnt = -1;
      obs_bad_xy = 0; obs_unstable = 0; obs_rv_cycles = 0;
      obs_lat_min = 9999; obs_lat_max = -9999;
      for (int n = 0; n < 100 && mb_ready !== 1'b1; n++) tick();
      mb_x = x; mb_y = y; mb_start = 1'b1; res_ready = 1'b0; pred_done = 1'b0;
      tick();
      cyc = 1; ref_cyc = 0; done_at = -100; bp_left = bp; k = 0; in_out = 0;
      held = '0; last_mode = '0;
      for (int n = 0; n < 3000; n++) begin
         pred_done = 1'b0;
         // requests while busy must be ignored, and so must the coordinates offered with them
         mb_start  = 1'($urandom_range(0, 1));
         mb_x      = BN'($urandom);
         if (pred_start === 1'b1) begin
            if (k < 4) obs_pack[7-2*k -: 2] = pred_mode;
            k++;
            last_mode = pred_mode;
            l = cyc - ref_cyc;
            if (l < obs_lat_min) obs_lat_min = l;
            if (l > obs_lat_max) obs_lat_max = l;
            if (pred_x !== x || pred_y !== y) obs_bad_xy++;
            done_at = cyc + lat;
         end
         if (mb_done === 1'b1) begin
            l = cyc - ref_cyc;
            if (l < obs_lat_min) obs_lat_min = l;
            if (l > obs_lat_max) obs_lat_max = l;
            obs_done = 1; obs_err = int'(mb_err); obs_cnt = int'(mb_mode_cnt);
            break;
         end
         if (res_valid === 1'b1) begin
            obs_rv_cycles++;
            if (!in_out) begin
               in_out = 1; held = res_mode;
               l = cyc - done_at;
               if (l < obs_lat_min) obs_lat_min = l;
               if (l > obs_lat_max) obs_lat_max = l;
               if (res_mode !== last_mode) obs_unstable++;
            end else if (res_mode !== held || pred_start === 1'b1) begin
               obs_unstable++;
            end
            if (bp_left > 0) begin
               res_ready = 1'b0; bp_left--;
            end else begin
               res_ready = 1'b1; ref_cyc = cyc; in_out = 0; bp_left = bp;
            end
         end else begin
            res_ready = 1'($urandom_range(0, 1));
         end
         if (cyc == done_at) pred_done = 1'b1;
         tick();
         cyc++;
      end
      obs_pack[10:8] = (k > 4) ? 3'd7 : 3'(k);
      mb_start = 1'b0; pred_done = 1'b0; res_ready = 1'b0;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [32:0] got, got_e, exp_v;
      rst_n = 1'b0;
      tick(); tick();
      exp_v = {1'b1, 32'b0};
      got   = {mb_ready, busy, pred_start, res_valid, mb_done, mb_err, mb_mode_cnt,
               pred_mode, res_mode, pred_x, pred_y};
      got_e = {mb_ready_e, busy_e, pred_start_e, res_valid_e, mb_done_e, mb_err_e,
               mb_mode_cnt_e, pred_mode_e, res_mode_e, pred_x_e, pred_y_e};
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, exp_v); end
      n_tests++;
      if (got_e !== exp_v) begin n_fail++; $display("FAIL reset_outputs_e: got %h expected %h", got_e, exp_v); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_dc();
      logic [10:0] e;
      e = model_pack(0, 0, 4'b1111);
      run_mb('0, '0, 1, 0);
      n_tests++;
      if (obs_pack !== e) begin n_fail++; $display("FAIL single_modes: got %h expected %h", obs_pack, e); end
      n_tests++;
      if ({obs_done, obs_cnt, obs_err} !== {32'd1, 32'd1, 32'd0}) begin
         n_fail++; $display("FAIL single_report: done=%0d cnt=%0d err=%0d expected 1 1 0", obs_done, obs_cnt, obs_err);
      end
      n_tests++;
      if (obs_lat_min !== 1 || obs_lat_max !== 1) begin
         n_fail++; $display("FAIL single_latency: min=%0d max=%0d expected 1", obs_lat_min, obs_lat_max);
      end
   endtask

   task automatic test_edges();
      int xs[2] = '{3, 0};
      int ys[2] = '{0, 2};
      logic [10:0] e;
      for (int i = 0; i < 2; i++) begin
         e = model_pack(xs[i], ys[i], 4'b1111);
         run_mb(BN'(xs[i]), BN'(ys[i]), int'($urandom_range(1, 5)), 0);
         n_tests++;
         if (obs_pack !== e) begin n_fail++; $display("FAIL edge_modes[%0d]: got %h expected %h", i, obs_pack, e); end
         n_tests++;
         if (obs_cnt !== int'(e[10:8]) || obs_err !== 0) begin
            n_fail++; $display("FAIL edge_report[%0d]: cnt=%0d err=%0d expected %0d 0", i, obs_cnt, obs_err, e[10:8]);
         end
      end
   endtask

   task automatic test_all_modes();
      logic [10:0] e;
      e = model_pack(1, 1, 4'b1111);
      run_mb(BN'(1), BN'(1), 17, 0);
      n_tests++;
      if (obs_pack !== e) begin n_fail++; $display("FAIL all_modes: got %h expected %h", obs_pack, e); end
      n_tests++;
      if (obs_bad_xy !== 0) begin n_fail++; $display("FAIL all_pred_xy: bad=%0d expected 0", obs_bad_xy); end
      n_tests++;
      if (obs_cnt !== 4 || obs_err !== 0) begin
         n_fail++; $display("FAIL all_report: cnt=%0d err=%0d expected 4 0", obs_cnt, obs_err);
      end
      n_tests++;
      if (obs_lat_min !== 1 || obs_lat_max !== 1) begin
         n_fail++; $display("FAIL all_latency: min=%0d max=%0d expected 1", obs_lat_min, obs_lat_max);
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] e;
      e = model_pack(1, 0, 4'b1111);
      run_mb(BN'(1), BN'(0), 3, 5);
      n_tests++;
      if (obs_pack !== e) begin n_fail++; $display("FAIL bp_modes: got %h expected %h", obs_pack, e); end
      n_tests++;
      if (obs_unstable !== 0) begin n_fail++; $display("FAIL bp_stable: violations=%0d expected 0", obs_unstable); end
      n_tests++;
      if (obs_rv_cycles !== int'(e[10:8]) * 6) begin
         n_fail++; $display("FAIL bp_valid_cycles: got %0d expected %0d", obs_rv_cycles, int'(e[10:8]) * 6);
      end
      n_tests++;
      if (obs_lat_min !== 1 || obs_lat_max !== 1) begin
         n_fail++; $display("FAIL bp_latency: min=%0d max=%0d expected 1", obs_lat_min, obs_lat_max);
      end
   endtask

   task automatic test_random();
      int x, y, lat, bp;
      logic [10:0] e;
      for (int i = 0; i < 8; i++) begin
         x   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 1023));
         y   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 1023));
         lat = int'($urandom_range(1, 20));
         bp  = int'($urandom_range(0, 3));
         e   = model_pack(x, y, 4'b1111);
         run_mb(BN'(x), BN'(y), lat, bp);
         n_tests++;
         if (obs_pack !== e || obs_cnt !== int'(e[10:8]) || obs_err !== 0 || obs_bad_xy !== 0 ||
             obs_unstable !== 0 || obs_rv_cycles !== int'(e[10:8]) * (bp + 1) ||
             obs_lat_min !== 1 || obs_lat_max !== 1) begin
            n_fail++;
            $display("FAIL random[%0d] x=%0d y=%0d: modes %h cnt %0d err %0d xy %0d unst %0d rv %0d lat %0d..%0d expected modes %h cnt %0d rv %0d",
                     i, x, y, obs_pack, obs_cnt, obs_err, obs_bad_xy, obs_unstable, obs_rv_cycles,
                     obs_lat_min, obs_lat_max, e, e[10:8], int'(e[10:8]) * (bp + 1));
         end
      end
   endtask

   task automatic test_timeout();
      int ps, rv, done_c, errv, cntv;
      for (int n = 0; n < 100 && mb_ready !== 1'b1; n++) tick();
      mb_x = BN'(5); mb_y = BN'(7); mb_start = 1'b1; pred_done = 1'b0; res_ready = 1'b0;
      tick();
      ps = 0; rv = 0; done_c = -1; errv = -1; cntv = -1;
      for (int c = 1; c < TO + 20; c++) begin
         if (pred_start === 1'b1) ps++;
         if (res_valid === 1'b1) rv++;
         if (mb_done === 1'b1) begin
            done_c = c; errv = int'(mb_err); cntv = int'(mb_mode_cnt);
            break;
         end
         mb_start = 1'($urandom_range(0, 1));
         mb_x     = BN'($urandom);
         tick();
      end
      n_tests++;
      if (done_c !== TO + 2) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", done_c, TO + 2); end
      n_tests++;
      if (errv !== 1 || cntv !== 0) begin n_fail++; $display("FAIL timeout_report: err=%0d cnt=%0d expected 1 0", errv, cntv); end
      n_tests++;
      if (ps !== 1 || rv !== 0 || pred_x !== BN'(5)) begin
         n_fail++; $display("FAIL timeout_busy_ignore: starts=%0d valids=%0d pred_x=%0d expected 1 0 5", ps, rv, pred_x);
      end
      mb_start = 1'b0;
      tick();
      n_tests++;
      if (mb_ready !== 1'b1 || busy !== 1'b0 || pred_start !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: ready=%b busy=%b start=%b expected 1 0 0", mb_ready, busy, pred_start);
      end
   endtask

   task automatic test_stuck_done();
      int rv;
      logic [2:0] got;
      pred_done = 1'b1;
      mb_x = '0; mb_y = '0; mb_start = 1'b1; res_ready = 1'b0;
      tick();
      mb_start = 1'b0;
      // cycle 1: LAUNCH; the error of the previous MB is cleared by this accept
      got = {pred_start, pred_mode == 2'd0, mb_err};
      n_tests++;
      if (got !== 3'b110) begin n_fail++; $display("FAIL stuck_launch: got %b expected 110", got); end
      rv = 0;
      for (int c = 2; c <= 7; c++) begin
         tick();
         if (res_valid === 1'b1) rv++;
      end
      n_tests++;
      if (rv !== 0) begin n_fail++; $display("FAIL stuck_high_completion: valids=%0d expected 0", rv); end
      pred_done = 1'b0;
      tick();
      pred_done = 1'b1;
      tick();
      pred_done = 1'b0;
      n_tests++;
      if (res_valid !== 1'b1 || res_mode !== 2'd0) begin
         n_fail++; $display("FAIL stuck_edge_result: valid=%b mode=%0d expected 1 0", res_valid, res_mode);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_tests++;
      if ({mb_done, mb_err, mb_mode_cnt} !== 5'b10001) begin
         n_fail++; $display("FAIL stuck_report: done=%b err=%b cnt=%0d expected 1 0 1", mb_done, mb_err, mb_mode_cnt);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [32:0] got, exp_v;
      int dn;
      for (int n = 0; n < 100 && mb_ready !== 1'b1; n++) tick();
      mb_x = BN'(1); mb_y = BN'(1); mb_start = 1'b1;
      tick();
      mb_start = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      exp_v = {1'b1, 32'b0};
      got   = {mb_ready, busy, pred_start, res_valid, mb_done, mb_err, mb_mode_cnt,
               pred_mode, res_mode, pred_x, pred_y};
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_mid_outputs: got %h expected %h", got, exp_v); end
      tick();
      rst_n = 1'b1;
      dn = 0;
      for (int c = 0; c < 30; c++) begin
         pred_done = 1'($urandom_range(0, 1));
         tick();
         if (mb_done === 1'b1 || pred_start === 1'b1) dn++;
      end
      pred_done = 1'b0;
      n_tests++;
      if (dn !== 0 || mb_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid_quiet: events=%0d ready=%b expected 0 1", dn, mb_ready);
      end
   endtask

   task automatic test_empty_mask();
      logic [10:0] e;
      logic [5:0]  got, exp_v;
      int          ps;
      e = model_pack(0, 0, 4'b1110);
      mb_x = '0; mb_y = '0; mb_start_e = 1'b1;
      tick();
      mb_start_e = 1'b0;
      got   = {mb_done_e, mb_mode_cnt_e, mb_err_e, pred_start_e};
      exp_v = {1'b1, e[10:8], 1'b0, 1'b0};
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL empty_mask_report: got %b expected %b", got, exp_v); end
      ps = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (pred_start_e === 1'b1 || mb_done_e === 1'b1) ps++;
      end
      n_tests++;
      if (ps !== 0 || mb_ready_e !== 1'b1) begin
         n_fail++; $display("FAIL empty_mask_idle: events=%0d ready=%b expected 0 1", ps, mb_ready_e);
      end
   endtask

   initial begin
      test_reset();
      test_single_dc();
      test_edges();
      test_all_modes();
      test_backpressure();
      test_random();
      test_timeout();
      test_stuck_done();
      test_reset_mid();
      test_empty_mask();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
